// File: rtl/poly_mul_negacyclic_stream.sv
// rtl/poly_mul_negacyclic_stream.sv - streamed negacyclic multiply-accumulate acc += a*s mod (x^N+1) over Z/2^QW
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   start, acc_clear, drain_en  operation request; clear/drain options sampled with start in IDLE
//   s_valid/s_ready/s_data      secret stream, SW-bit sign-magnitude coefficients, coefficient 0 in LSBs
//   a_valid/a_ready/a_data      polynomial stream, QW-bit coefficients packed LSB-first across words
//   out_valid/out_ready/out_data result stream, DW/16 coefficients per word, each zero-extended to 16 bits
//   busy, done                  high outside IDLE; one-cycle completion pulse
module poly_mul_negacyclic_stream #(
  parameter int N          = 256,
  parameter int QW         = 13,
  parameter int SW         = 4,
  parameter int DW         = 64,
  parameter int ROUND_INIT = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          acc_clear,
  input  logic          drain_en,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [DW-1:0] a_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          busy,
  output logic          done
);

  localparam int SPW      = DW / SW;        // secret coefficients per input word
  localparam int NS_WORDS = N * SW / DW;
  localparam int NA_WORDS = N * QW / DW;
  localparam int CPW      = DW / 16;        // result coefficients per output word
  localparam int ND_WORDS = N / CPW;
  localparam int BW       = 2 * DW + QW - 1; // gearbox buffer width
  localparam int FW       = $clog2(BW + 1);
  localparam int SCW      = $clog2(NS_WORDS + 1);
  localparam int AW       = $clog2(NA_WORDS + 1);
  localparam int MW       = $clog2(N + 1);
  localparam int DCW      = $clog2(ND_WORDS + 1);

  typedef enum logic [1:0] {IDLE, LOAD_S, MAC, DRAIN} state_t;

  state_t state, state_next;
  logic   done_next;
  logic   drain_q;

  logic [SCW-1:0] s_cnt;
  logic [AW-1:0]  a_cnt;
  logic [MW-1:0]  m_cnt;
  logic [DCW-1:0] d_cnt;

  logic [BW-1:0] gbuf, comb_buf, gbuf_nxt;
  logic [FW-1:0] fill, comb_fill, fill_nxt;
  logic          a_fire, consume;
  logic [QW-1:0] a_j;

  logic [QW-1:0] acc   [N];
  logic [QW-1:0] acc_d [N];
  logic [QW-1:0] prod  [N];
  logic [SW-1:0] sec   [N];
  logic [SW-1:0] sec_d [N];

  assign busy      = (state != IDLE);
  assign s_ready   = (state == LOAD_S);
  assign out_valid = (state == DRAIN);
  // Accept a word only while it is guaranteed to fit after this cycle's consume,
  // and never beyond the exact number of words that make up the polynomial.
  assign a_ready   = (state == MAC) && (fill <= FW'(DW + QW - 1)) && (a_cnt < AW'(NA_WORDS));
  assign a_fire    = a_valid && a_ready;

  // The incoming word is merged before extraction so a coefficient can be taken
  // in the same cycle its bits arrive; this keeps an unstalled MAC at N cycles.
  always_comb begin
    comb_buf  = gbuf;
    comb_fill = fill;
    if (a_fire) begin
      comb_buf  = gbuf | (BW'(a_data) << fill);
      comb_fill = fill + FW'(DW);
    end
    consume  = (state == MAC) && (comb_fill >= FW'(QW));
    a_j      = comb_buf[QW-1:0];
    gbuf_nxt = consume ? (comb_buf >> QW) : comb_buf;
    fill_nxt = consume ? (comb_fill - FW'(QW)) : comb_fill;
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      prod[i] = a_j * QW'(sec[i][SW-2:0]);
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      acc_d[i] = acc[i];
      sec_d[i] = sec[i];
    end
    case (state)
      IDLE: begin
        if (start && acc_clear) begin
          for (int i = 0; i < N; i++) acc_d[i] = QW'(ROUND_INIT);
        end
      end
      LOAD_S: begin
        // Shift down so the first word ends up at coefficient 0 after the last word.
        if (s_valid) begin
          for (int i = 0; i < N - SPW; i++) sec_d[i] = sec[i + SPW];
          for (int j = 0; j < SPW; j++) sec_d[N - SPW + j] = s_data[j*SW +: SW];
        end
      end
      MAC: begin
        if (consume) begin
          for (int i = 0; i < N; i++) begin
            acc_d[i] = sec[i][SW-1] ? (acc[i] - prod[i]) : (acc[i] + prod[i]);
          end
          // Multiply the secret by x: wrapped coefficient changes sign.
          for (int i = 1; i < N; i++) sec_d[i] = sec[i - 1];
          sec_d[0] = {~sec[N-1][SW-1], sec[N-1][SW-2:0]};
        end
      end
      DRAIN: begin
        // Rotate by one output word; after all words the order is restored.
        if (out_ready) begin
          for (int i = 0; i < N - CPW; i++) acc_d[i] = acc[i + CPW];
          for (int j = 0; j < CPW; j++) acc_d[N - CPW + j] = acc[j];
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    out_data = '0;
    for (int j = 0; j < CPW; j++) out_data[16*j +: 16] = 16'(acc[j]);
  end

  always_comb begin
    state_next = state;
    done_next  = 1'b0;
    case (state)
      IDLE:   if (start) state_next = LOAD_S;
      LOAD_S: if (s_valid && (s_cnt == SCW'(NS_WORDS - 1))) state_next = MAC;
      MAC: begin
        if (consume && (m_cnt == MW'(N - 1))) begin
          if (drain_q) begin
            state_next = DRAIN;
          end else begin
            state_next = IDLE;
            done_next  = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (out_ready && (d_cnt == DCW'(ND_WORDS - 1))) begin
          state_next = IDLE;
          done_next  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      done    <= 1'b0;
      drain_q <= 1'b0;
      s_cnt   <= '0;
      a_cnt   <= '0;
      m_cnt   <= '0;
      d_cnt   <= '0;
      fill    <= '0;
      gbuf    <= '0;
    end else begin
      state <= state_next;
      done  <= done_next;
      case (state)
        IDLE: begin
          if (start) begin
            drain_q <= drain_en;
            s_cnt   <= '0;
            a_cnt   <= '0;
            m_cnt   <= '0;
            d_cnt   <= '0;
            fill    <= '0;
            gbuf    <= '0;
          end
        end
        LOAD_S: if (s_valid) s_cnt <= s_cnt + SCW'(1);
        MAC: begin
          if (a_fire)  a_cnt <= a_cnt + AW'(1);
          if (consume) m_cnt <= m_cnt + MW'(1);
          gbuf <= gbuf_nxt;
          fill <= fill_nxt;
        end
        DRAIN: if (out_ready) d_cnt <= d_cnt + DCW'(1);
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        acc[i] <= '0;
        sec[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N; i++) begin
        acc[i] <= acc_d[i];
        sec[i] <= sec_d[i];
      end
    end
  end

endmodule

// File: tb/tb_poly_mul_negacyclic_stream.sv
// tb/tb_poly_mul_negacyclic_stream.sv - directed self-checking bench for poly_mul_negacyclic_stream
module tb_poly_mul_negacyclic_stream;

  logic        clk = 1'b0;
  logic        rst, start, acc_clear, drain_en;
  logic        s_valid, a_valid, out_ready;
  logic [63:0] s_data, a_data;
  logic        s_ready, a_ready, out_valid, busy, done;
  logic [63:0] out_data;
  logic        s_ready2, a_ready2, out_valid2, busy2, done2;
  logic [63:0] out_data2;

  always #5 clk = ~clk;

  poly_mul_negacyclic_stream dut (
    .clk(clk), .rst(rst), .start(start), .acc_clear(acc_clear), .drain_en(drain_en),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .a_valid(a_valid), .a_ready(a_ready), .a_data(a_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done)
  );

  poly_mul_negacyclic_stream #(.ROUND_INIT(4)) dut_ri (
    .clk(clk), .rst(rst), .start(start), .acc_clear(acc_clear), .drain_en(drain_en),
    .s_valid(s_valid), .s_ready(s_ready2), .s_data(s_data),
    .a_valid(a_valid), .a_ready(a_ready2), .a_data(a_data),
    .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
    .busy(busy2), .done(done2)
  );

  int compared = 0;
  int mismatched = 0;

  logic [12:0] a_coef [256];
  logic [3:0]  s_coef [256];
  logic [15:0] got1 [256];
  logic [15:0] got2 [256];
  int          r_swords, r_awords, r_mac, r_words, r_stable_bad;
  logic        r_done_end, r_done_after;
  logic [3:0]  r_rst_flags;
  logic [63:0] r_rst_data;

  function automatic logic [63:0] sword(input int w);
    logic [63:0] v;
    v = '0;
    for (int c = 0; c < 16; c++) v[4*c +: 4] = s_coef[16*w + c];
    return v;
  endfunction

  function automatic logic [63:0] aword(input int w);
    logic [63:0] v;
    logic [12:0] cf;
    int b;
    v = '0;
    for (int k = 0; k < 64; k++) begin
      b = 64*w + k;
      cf = a_coef[b/13];
      v[k] = cf[b%13];
    end
    return v;
  endfunction

  // amode 0: a_i = i, amode 1: a_i = 8191
  task automatic set_ops(input int s_idx, input logic [3:0] s_val, input int amode);
    for (int i = 0; i < 256; i++) begin
      s_coef[i] = 4'd0;
      a_coef[i] = (amode == 0) ? 13'(i) : 13'd8191;
    end
    s_coef[s_idx] = s_val;
  endtask

  task automatic run_op(input logic clr, input logic drn, input logic gap, input logic stall,
                        input logic start_mid, input int rst_at);
    int cyc;
    logic fire, holding;
    logic [63:0] hold;
    r_swords = 0; r_awords = 0; r_mac = 0; r_words = 0; r_stable_bad = 0;
    r_done_end = 1'b0; r_done_after = 1'b1; r_rst_flags = '1; r_rst_data = '1;
    for (int i = 0; i < 256; i++) begin got1[i] = '1; got2[i] = '1; end
    @(posedge clk); #1;
    start = 1'b1; acc_clear = clr; drain_en = drn;
    @(posedge clk); #1;
    start = 1'b0; acc_clear = 1'b0; drain_en = 1'b0;
    cyc = 0;
    while (r_swords < 16 && cyc < 200) begin
      s_valid = 1'b1;
      s_data  = sword(r_swords);
      fire    = s_ready;
      @(posedge clk); #1;
      if (fire) r_swords++;
      cyc++;
    end
    s_valid = 1'b0;
    cyc = 0;
    while (busy && !out_valid && cyc < 2000) begin
      if (rst_at >= 0 && r_mac == rst_at) begin
        rst = 1'b1; a_valid = 1'b0;
        #1;
        r_rst_flags = {busy, s_ready, a_ready, out_valid};
        r_rst_data  = out_data;
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      start   = start_mid && (r_mac == 50);
      a_valid = (r_awords < 52) && (!gap || (r_mac % 2 == 0));
      a_data  = aword((r_awords < 52) ? r_awords : 0);
      fire    = a_valid && a_ready;
      @(posedge clk); #1;
      if (fire) r_awords++;
      r_mac++;
      cyc++;
    end
    start = 1'b0; a_valid = 1'b0;
    if (!drn) begin
      r_done_end = done && !busy;
    end else begin
      cyc = 0; holding = 1'b0; hold = '0;
      while (r_words < 64 && cyc < 2000) begin
        out_ready = !(stall && cyc >= 30 && cyc < 40);
        if (holding && out_data !== hold) r_stable_bad++;
        fire    = out_valid && out_ready;
        holding = out_valid && !out_ready;
        hold    = out_data;
        if (fire) begin
          for (int j = 0; j < 4; j++) begin
            got1[4*r_words + j] = out_data[16*j +: 16];
            got2[4*r_words + j] = out_data2[16*j +: 16];
          end
        end
        @(posedge clk); #1;
        if (fire) r_words++;
        cyc++;
      end
      out_ready = 1'b1;
      r_done_end = done && !busy;
    end
    @(posedge clk); #1;
    r_done_after = done;
  endtask

  task automatic test_reset;
    @(posedge clk); #1;
    compared++;
    if ({busy, done, s_ready, a_ready, out_valid} !== 5'b0) begin
      mismatched++; $display("FAIL reset_flags: got %b required 00000", {busy, done, s_ready, a_ready, out_valid});
    end
    compared++;
    if ({busy2, done2, s_ready2, a_ready2, out_valid2} !== 5'b0) begin
      mismatched++; $display("FAIL reset_flags_ri: got %b required 00000", {busy2, done2, s_ready2, a_ready2, out_valid2});
    end
    rst = 1'b0;
    @(posedge clk); #1;
    compared++;
    if (out_data !== 64'd0 || out_data2 !== 64'd0) begin
      mismatched++; $display("FAIL reset_acc: got %h / %h required 0", out_data, out_data2);
    end
    compared++;
    if ({busy, done, s_ready, a_ready, out_valid} !== 5'b0) begin
      mismatched++; $display("FAIL idle_flags: got %b required 00000", {busy, done, s_ready, a_ready, out_valid});
    end
  endtask

  task automatic test_identity;
    set_ops(0, 4'b0001, 0);
    run_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, -1);
    compared++;
    if (r_swords != 16) begin mismatched++; $display("FAIL id_swords: got %0d required 16", r_swords); end
    compared++;
    if (r_awords != 52) begin mismatched++; $display("FAIL id_awords: got %0d required 52", r_awords); end
    compared++;
    if (r_mac != 256) begin mismatched++; $display("FAIL id_mac_cycles: got %0d required 256", r_mac); end
    compared++;
    if (r_words != 64) begin mismatched++; $display("FAIL id_out_words: got %0d required 64", r_words); end
    compared++;
    if (r_done_end !== 1'b1) begin mismatched++; $display("FAIL id_done_pulse: got %b required 1", r_done_end); end
    compared++;
    if (r_done_after !== 1'b0) begin mismatched++; $display("FAIL id_done_width: got %b required 0", r_done_after); end
    for (int i = 0; i < 256; i++) begin
      compared++;
      if (got1[i] !== 16'(i)) begin mismatched++; $display("FAIL id_coef[%0d]: got %0d required %0d", i, got1[i], i); end
      compared++;
      if (got2[i] !== 16'(i + 4)) begin mismatched++; $display("FAIL id_ri_coef[%0d]: got %0d required %0d", i, got2[i], i + 4); end
    end
  endtask

  task automatic test_accumulate;
    set_ops(0, 4'b0001, 0);
    run_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    compared++;
    if (r_mac != 256) begin mismatched++; $display("FAIL acc_mac_cycles: got %0d required 256", r_mac); end
    for (int i = 0; i < 256; i++) begin
      compared++;
      if (got1[i] !== 16'(2*i)) begin mismatched++; $display("FAIL acc_coef[%0d]: got %0d required %0d", i, got1[i], 2*i); end
    end
  endtask

  task automatic test_shift;
    set_ops(1, 4'b0001, 0);
    run_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    compared++;
    if (got1[0] !== 16'd7937) begin mismatched++; $display("FAIL shift_coef[0]: got %0d required 7937", got1[0]); end
    for (int i = 1; i < 256; i++) begin
      compared++;
      if (got1[i] !== 16'(i - 1)) begin mismatched++; $display("FAIL shift_coef[%0d]: got %0d required %0d", i, got1[i], i - 1); end
    end
  endtask

  task automatic test_negative;
    set_ops(0, 4'b1001, 1);
    run_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    for (int i = 0; i < 256; i++) begin
      compared++;
      if (got1[i] !== 16'd1) begin mismatched++; $display("FAIL neg1_coef[%0d]: got %0d required 1", i, got1[i]); end
    end
    set_ops(0, 4'b1000, 1);
    run_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    for (int i = 0; i < 256; i++) begin
      compared++;
      if (got1[i] !== 16'd0) begin mismatched++; $display("FAIL negzero_coef[%0d]: got %0d required 0", i, got1[i]); end
    end
  endtask

  task automatic test_round_init;
    set_ops(0, 4'b0000, 0);
    run_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    for (int i = 0; i < 256; i++) begin
      compared++;
      if (got1[i] !== 16'd0) begin mismatched++; $display("FAIL zero_coef[%0d]: got %0d required 0", i, got1[i]); end
      compared++;
      if (got2[i] !== 16'd4) begin mismatched++; $display("FAIL round_init_coef[%0d]: got %0d required 4", i, got2[i]); end
    end
  endtask

  task automatic test_stall;
    set_ops(0, 4'b0001, 0);
    run_op(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, -1);
    compared++;
    if (r_awords != 52) begin mismatched++; $display("FAIL stall_awords: got %0d required 52", r_awords); end
    compared++;
    if (r_words != 64) begin mismatched++; $display("FAIL stall_out_words: got %0d required 64", r_words); end
    compared++;
    if (r_stable_bad != 0) begin mismatched++; $display("FAIL stall_stable: got %0d changes required 0", r_stable_bad); end
    compared++;
    if (r_done_end !== 1'b1) begin mismatched++; $display("FAIL stall_done: got %b required 1", r_done_end); end
    for (int i = 0; i < 256; i++) begin
      compared++;
      if (got1[i] !== 16'(i)) begin mismatched++; $display("FAIL stall_coef[%0d]: got %0d required %0d", i, got1[i], i); end
    end
  endtask

  task automatic test_reset_mac;
    set_ops(0, 4'b0001, 0);
    run_op(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 100);
    compared++;
    if (r_rst_flags !== 4'b0) begin mismatched++; $display("FAIL rst_async_flags: got %b required 0000", r_rst_flags); end
    compared++;
    if (r_rst_data !== 64'd0) begin mismatched++; $display("FAIL rst_async_acc: got %h required 0", r_rst_data); end
    run_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    for (int i = 0; i < 256; i++) begin
      compared++;
      if (got1[i] !== 16'(i)) begin mismatched++; $display("FAIL rst_rerun_coef[%0d]: got %0d required %0d", i, got1[i], i); end
    end
  endtask

  task automatic test_no_drain;
    set_ops(0, 4'b0001, 0);
    run_op(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -1);
    compared++;
    if (r_mac != 256) begin mismatched++; $display("FAIL nodrain_mac_cycles: got %0d required 256", r_mac); end
    compared++;
    if (r_done_end !== 1'b1) begin mismatched++; $display("FAIL nodrain_done: got %b required 1", r_done_end); end
    compared++;
    if (r_done_after !== 1'b0) begin mismatched++; $display("FAIL nodrain_done_width: got %b required 0", r_done_after); end
    run_op(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -1);
    for (int i = 0; i < 256; i++) begin
      compared++;
      if (got1[i] !== 16'(2*i)) begin mismatched++; $display("FAIL nodrain_coef[%0d]: got %0d required %0d", i, got1[i], 2*i); end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; acc_clear = 1'b0; drain_en = 1'b0;
    s_valid = 1'b0; s_data = '0; a_valid = 1'b0; a_data = '0; out_ready = 1'b1;
    test_reset;
    test_identity;
    test_accumulate;
    test_shift;
    test_negative;
    test_round_init;
    test_stall;
    test_reset_mac;
    test_no_drain;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
